async_fifo_ptr_ctrl: RTL and testbench

- Parametrised pointer/flag controller for one side of a dual-clock FIFO. Generalises the fixed 4-bit gray encoder to ADDR_W+1 bits and adds registered pointers.
- Adds remote-pointer synchronisation, gray-to-binary decode, registered full or empty flag, almost flag and fill level.
- One instance per side: SIDE=0 in the write domain drives full, SIDE=1 in the read domain drives empty.

---
 rtl/async_fifo_ptr_ctrl.sv | 123 ++++++++++++
 tb/tb_async_fifo_ptr_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_ptr_ctrl.sv
// Dual-clock FIFO pointer/flag controller for one side (SIDE=0 write/full, SIDE=1 read/empty).
// Latency: local advance -> ptr/flag/level on the same edge; remote_gray -> flag/level after SYNC_STAGES+1 edges.
// Backpressure: accept = inc && !flag; a refused inc is dropped and the pointer holds until the remote pointer moves.
module async_fifo_ptr_ctrl #(
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int SIDE        = 0,
    parameter int ALMOST_TH   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic [ADDR_W:0]   remote_gray,
    output logic              accept,
    output logic [ADDR_W:0]   ptr_bin,
    output logic [ADDR_W:0]   ptr_gray,
    output logic [ADDR_W-1:0] addr,
    output logic              flag,
    output logic              almost_flag,
    output logic [ADDR_W:0]   level
);

    localparam int PW = ADDR_W + 1;

    logic [ADDR_W:0] bin_next;
    logic [ADDR_W:0] gray_next;
    logic [ADDR_W:0] sync_q [SYNC_STAGES];
    logic [ADDR_W:0] rsync;
    logic [ADDR_W:0] rbin;
    logic [ADDR_W:0] level_next;
    logic            flag_next;
    logic            almost_next;

    // The pointer only moves when the side is not blocked by its own flag.
    assign accept    = inc && !flag;
    assign bin_next  = ptr_bin + PW'(accept);
    assign gray_next = bin_next ^ (bin_next >> 1);
    assign rsync     = sync_q[SYNC_STAGES-1];
    assign addr      = ptr_bin[ADDR_W-1:0];

    // Remote gray pointer synchroniser; the only path from remote_gray into this domain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= remote_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Gray-to-binary decode of the synchronised remote pointer, MSB downwards.
    always_comb begin
        rbin         = '0;
        rbin[ADDR_W] = rsync[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ rsync[i];
        end
    end

    // Local pointer and occupancy register; the gray copy is registered so it never glitches across domains.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_bin  <= '0;
            ptr_gray <= '0;
            level    <= '0;
        end else begin
            ptr_bin  <= bin_next;
            ptr_gray <= gray_next;
            level    <= level_next;
        end
    end

    if (SIDE == 0) begin : g_write
        localparam logic [ADDR_W:0] DEPTH      = PW'(1) << ADDR_W;
        // Full pattern: remote pointer one lap behind, i.e. top two gray bits inverted.
        localparam logic [ADDR_W:0] FULL_MASK  = PW'(3) << (ADDR_W - 1);
        localparam logic [ADDR_W:0] ALMOST_LVL = DEPTH - PW'(ALMOST_TH);
        localparam logic            ALMOST_RST = (ALMOST_TH == (1 << ADDR_W));

        // Full/almost-full evaluated from the post-push pointer so a push that fills is flagged on the same edge.
        always_comb begin
            flag_next   = (gray_next == (rsync ^ FULL_MASK));
            level_next  = bin_next - rbin;
            almost_next = (level_next >= ALMOST_LVL);
        end

        // Registered full and almost-full flags.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                flag        <= 1'b0;
                almost_flag <= ALMOST_RST;
            end else begin
                flag        <= flag_next;
                almost_flag <= almost_next;
            end
        end
    end else begin : g_read
        localparam logic [ADDR_W:0] ALMOST_LVL = PW'(ALMOST_TH);

        // Empty/almost-empty evaluated from the post-pop pointer so a pop that drains is flagged on the same edge.
        always_comb begin
            flag_next   = (gray_next == rsync);
            level_next  = rbin - bin_next;
            almost_next = (level_next <= ALMOST_LVL);
        end

        // Registered empty and almost-empty flags; an empty FIFO comes out of reset flagged.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                flag        <= 1'b1;
                almost_flag <= 1'b1;
            end else begin
                flag        <= flag_next;
                almost_flag <= almost_next;
            end
        end
    end

endmodule

// File: tb/tb_async_fifo_ptr_ctrl.sv
module tb_async_fifo_ptr_ctrl;

    localparam int NI = 4;
    localparam int P_AW [NI] = '{3, 3, 1, 2};
    localparam int P_SS [NI] = '{2, 2, 3, 4};
    localparam int P_SD [NI] = '{0, 1, 0, 1};
    localparam int P_TH [NI] = '{1, 1, 0, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [NI-1:0] inc;
    logic [NI-1:0] acc;
    logic [NI-1:0] flg;
    logic [NI-1:0] alm;

    logic [3:0] rem0, bin0, gray0, lvl0;
    logic [2:0] addr0;
    logic [3:0] rem1, bin1, gray1, lvl1;
    logic [2:0] addr1;
    logic [1:0] rem2, bin2, gray2, lvl2;
    logic [0:0] addr2;
    logic [2:0] rem3, bin3, gray3, lvl3;
    logic [1:0] addr3;

    async_fifo_ptr_ctrl #(.ADDR_W(P_AW[0]), .SYNC_STAGES(P_SS[0]), .SIDE(P_SD[0]), .ALMOST_TH(P_TH[0])) u_i0 (
        .clk(clk), .rst_n(rst_n), .inc(inc[0]), .remote_gray(rem0), .accept(acc[0]),
        .ptr_bin(bin0), .ptr_gray(gray0), .addr(addr0), .flag(flg[0]), .almost_flag(alm[0]), .level(lvl0));
    async_fifo_ptr_ctrl #(.ADDR_W(P_AW[1]), .SYNC_STAGES(P_SS[1]), .SIDE(P_SD[1]), .ALMOST_TH(P_TH[1])) u_i1 (
        .clk(clk), .rst_n(rst_n), .inc(inc[1]), .remote_gray(rem1), .accept(acc[1]),
        .ptr_bin(bin1), .ptr_gray(gray1), .addr(addr1), .flag(flg[1]), .almost_flag(alm[1]), .level(lvl1));
    async_fifo_ptr_ctrl #(.ADDR_W(P_AW[2]), .SYNC_STAGES(P_SS[2]), .SIDE(P_SD[2]), .ALMOST_TH(P_TH[2])) u_i2 (
        .clk(clk), .rst_n(rst_n), .inc(inc[2]), .remote_gray(rem2), .accept(acc[2]),
        .ptr_bin(bin2), .ptr_gray(gray2), .addr(addr2), .flag(flg[2]), .almost_flag(alm[2]), .level(lvl2));
    async_fifo_ptr_ctrl #(.ADDR_W(P_AW[3]), .SYNC_STAGES(P_SS[3]), .SIDE(P_SD[3]), .ALMOST_TH(P_TH[3])) u_i3 (
        .clk(clk), .rst_n(rst_n), .inc(inc[3]), .remote_gray(rem3), .accept(acc[3]),
        .ptr_bin(bin3), .ptr_gray(gray3), .addr(addr3), .flag(flg[3]), .almost_flag(alm[3]), .level(lvl3));

    // Reference model: pointer as a lap counter, remote view as a delayed copy, flags from occupancy.
    int m_cnt  [NI];
    int m_lvl  [NI];
    int m_flag [NI];
    int m_alm  [NI];
    int m_dl   [NI][4];

    int n_vec = 0;
    int n_err = 0;
    bit acc_chk = 1'b0;

    typedef struct {
        int inst;
        bit rst;
        bit inc;
        int rem;
        bit cacc;
        bit acc;
        int bin;
        int gry;
        bit flg;
        bit alm;
        int lvl;
    } vec_t;

    vec_t tbl[$];
    int   gseq [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

    function automatic int gray_of(input int b);
        return b ^ (b >> 1);
    endfunction

    // Decode by search: the binary value whose gray code matches.
    function automatic int g2b(input int g, input int aw);
        for (int b = 0; b < (2 << aw); b++) begin
            if (gray_of(b) == g) return b;
        end
        return -1;
    endfunction

    function automatic vec_t mk(input int inst, input bit rst, input bit inc_i, input int rem,
                                input bit cacc, input bit acc_e, input int bin, input int gry,
                                input bit flg_e, input bit alm_e, input int lvl);
        vec_t v;
        v.inst = inst; v.rst = rst; v.inc = inc_i; v.rem = rem; v.cacc = cacc; v.acc = acc_e;
        v.bin = bin; v.gry = gry; v.flg = flg_e; v.alm = alm_e; v.lvl = lvl;
        return v;
    endfunction

    function automatic int get_rem(input int i);
        case (i)
            0:       return int'(rem0);
            1:       return int'(rem1);
            2:       return int'(rem2);
            default: return int'(rem3);
        endcase
    endfunction

    task automatic set_rem(input int i, input int g);
        case (i)
            0:       rem0 = 4'(g);
            1:       rem1 = 4'(g);
            2:       rem2 = 2'(g);
            default: rem3 = 3'(g);
        endcase
    endtask

    task automatic get_out(input int i, output int b, output int g, output int a, output int l);
        case (i)
            0:       begin b = int'(bin0); g = int'(gray0); a = int'(addr0); l = int'(lvl0); end
            1:       begin b = int'(bin1); g = int'(gray1); a = int'(addr1); l = int'(lvl1); end
            2:       begin b = int'(bin2); g = int'(gray2); a = int'(addr2); l = int'(lvl2); end
            default: begin b = int'(bin3); g = int'(gray3); a = int'(addr3); l = int'(lvl3); end
        endcase
    endtask

    task automatic chk(input string nm, input int i, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s[inst%0d]: got %0d, expected %0d", nm, i, act, exp);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            int mask, depth, s, used, a;
            mask  = (2 << P_AW[i]) - 1;
            depth = 1 << P_AW[i];
            s     = P_SS[i];
            if (!rst_n) begin
                m_cnt[i]  = 0;
                m_lvl[i]  = 0;
                m_flag[i] = P_SD[i];
                m_alm[i]  = (P_SD[i] != 0) ? 1 : ((P_TH[i] == depth) ? 1 : 0);
                for (int k = 0; k < 4; k++) m_dl[i][k] = 0;
            end else begin
                a        = (inc[i] && m_flag[i] == 0) ? 1 : 0;
                m_cnt[i] = (m_cnt[i] + a) & mask;
                used     = g2b(m_dl[i][s-1], P_AW[i]);
                for (int k = 3; k > 0; k--) m_dl[i][k] = m_dl[i][k-1];
                m_dl[i][0] = get_rem(i);
                if (P_SD[i] == 0) begin
                    m_lvl[i]  = (m_cnt[i] - used) & mask;
                    m_flag[i] = (m_lvl[i] == depth) ? 1 : 0;
                    m_alm[i]  = (m_lvl[i] >= depth - P_TH[i]) ? 1 : 0;
                end else begin
                    m_lvl[i]  = (used - m_cnt[i]) & mask;
                    m_flag[i] = (m_lvl[i] == 0) ? 1 : 0;
                    m_alm[i]  = (m_lvl[i] <= P_TH[i]) ? 1 : 0;
                end
            end
        end
    endtask

    // One clock: check accept before the edge, advance the model, check registers on the falling edge.
    task automatic cycle();
        int b, g, a, l;
        #1;
        if (acc_chk) begin
            for (int i = 0; i < NI; i++)
                chk("model accept", i, int'(acc[i]), (inc[i] && m_flag[i] == 0) ? 1 : 0);
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            get_out(i, b, g, a, l);
            chk("model ptr_bin", i, b, m_cnt[i]);
            chk("model ptr_gray", i, g, gray_of(m_cnt[i]));
            chk("model addr", i, a, m_cnt[i] & ((1 << P_AW[i]) - 1));
            chk("model flag", i, int'(flg[i]), m_flag[i]);
            chk("model almost", i, int'(alm[i]), m_alm[i]);
            chk("model level", i, l, m_lvl[i]);
        end
        acc_chk = 1'b1;
    endtask

    initial begin
        int b, g, a, l, prev;
        int rc [NI];
        int pin, pr;

        rst_n = 1'b0;
        inc   = '1;
        for (int i = 0; i < NI; i++) set_rem(i, 0);

        // Reset held two cycles with requests pending.
        cycle();
        cycle();
        get_out(1, b, g, a, l);
        chk("rst rd ptr_bin", 1, b, 0);
        chk("rst rd ptr_gray", 1, g, 0);
        chk("rst rd flag", 1, int'(flg[1]), 1);
        chk("rst rd almost", 1, int'(alm[1]), 1);
        chk("rst rd level", 1, l, 0);
        chk("rst rd accept", 1, int'(acc[1]), 0);
        chk("rst wr flag", 0, int'(flg[0]), 0);
        chk("rst wr almost", 0, int'(alm[0]), 0);

        // Write side: fill to full, rejected pushes, drain release, refill.
        for (int k = 1; k <= 8; k++)
            tbl.push_back(mk(0, 1, 1, 0, 1, 1, k, gseq[k % 16], k == 8, k >= 7, k));
        for (int k = 0; k < 2; k++)
            tbl.push_back(mk(0, 1, 1, 0, 1, 0, 8, 12, 1, 1, 8));
        for (int k = 0; k < 2; k++)
            tbl.push_back(mk(0, 1, 0, 1, 1, 0, 8, 12, 1, 1, 8));
        tbl.push_back(mk(0, 1, 0, 1, 1, 0, 8, 12, 0, 1, 7));
        tbl.push_back(mk(0, 1, 1, 1, 1, 1, 9, 13, 1, 1, 8));
        // Mid-operation reset at level 5 with a push pending; sync chain must come back empty.
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 5; k++)
            tbl.push_back(mk(0, 1, 1, 0, 1, 1, k, gseq[k], 0, 0, k));
        tbl.push_back(mk(0, 1, 0, 3, 1, 0, 5, 7, 0, 0, 5));
        tbl.push_back(mk(0, 0, 1, 3, 1, 1, 0, 0, 0, 0, 0));
        for (int k = 0; k < 2; k++)
            tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        // Read side: remote write arrives, pop to empty, refill to 5 and drain.
        for (int k = 0; k < 2; k++)
            tbl.push_back(mk(1, 1, 0, 1, 1, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 1, 0, 1, 1, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0));
        tbl.push_back(mk(1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0));
        for (int k = 0; k < 2; k++)
            tbl.push_back(mk(1, 1, 0, 7, 1, 0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(1, 1, 0, 7, 1, 0, 1, 1, 0, 0, 4));
        tbl.push_back(mk(1, 1, 1, 7, 1, 1, 2, 3, 0, 0, 3));
        tbl.push_back(mk(1, 1, 1, 7, 1, 1, 3, 2, 0, 0, 2));
        tbl.push_back(mk(1, 1, 1, 7, 1, 1, 4, 6, 0, 1, 1));
        tbl.push_back(mk(1, 1, 1, 7, 1, 1, 5, 7, 1, 1, 0));
        tbl.push_back(mk(1, 1, 1, 7, 1, 0, 5, 7, 1, 1, 0));

        foreach (tbl[k]) begin
            rst_n = tbl[k].rst;
            inc   = '0;
            inc[tbl[k].inst] = tbl[k].inc;
            set_rem(tbl[k].inst, tbl[k].rem);
            #1;
            if (tbl[k].cacc)
                chk($sformatf("row%0d accept", k), tbl[k].inst, int'(acc[tbl[k].inst]), int'(tbl[k].acc));
            cycle();
            get_out(tbl[k].inst, b, g, a, l);
            chk($sformatf("row%0d ptr_bin", k), tbl[k].inst, b, tbl[k].bin);
            chk($sformatf("row%0d ptr_gray", k), tbl[k].inst, g, tbl[k].gry);
            chk($sformatf("row%0d flag", k), tbl[k].inst, int'(flg[tbl[k].inst]), int'(tbl[k].flg));
            chk($sformatf("row%0d almost", k), tbl[k].inst, int'(alm[tbl[k].inst]), int'(tbl[k].alm));
            chk($sformatf("row%0d level", k), tbl[k].inst, l, tbl[k].lvl);
        end

        // Gray sweep over a full lap with a remote that trails the local pointer.
        rst_n = 1'b1;
        inc   = '0;
        prev  = 0;
        for (int k = 0; k < 16; k++) begin
            set_rem(0, gray_of(m_cnt[0]));
            inc[0] = 1'b1;
            cycle();
            get_out(0, b, g, a, l);
            chk($sformatf("sweep%0d gray", k), 0, g, gseq[(k + 1) % 16]);
            chk($sformatf("sweep%0d toggles", k), 0, $countones(g ^ prev), 1);
            prev = g;
        end

        // Randomised traffic against the model, legal remote pointers, occasional resets.
        rst_n = 1'b0;
        inc   = '0;
        for (int i = 0; i < NI; i++) begin
            rc[i] = 0;
            set_rem(i, 0);
        end
        cycle();
        pin = 50;
        pr  = 50;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 250 == 0) begin
                pin = $urandom_range(10, 90);
                pr  = $urandom_range(10, 90);
            end
            rst_n = ($urandom_range(0, 399) != 0);
            for (int i = 0; i < NI; i++) begin
                int mask, depth, occ;
                mask  = (2 << P_AW[i]) - 1;
                depth = 1 << P_AW[i];
                if (!rst_n) begin
                    rc[i] = 0;
                end else if (P_SD[i] == 0) begin
                    occ = (m_cnt[i] - rc[i]) & mask;
                    if (occ > 0 && $urandom_range(0, 99) < pr) rc[i] = (rc[i] + 1) & mask;
                end else begin
                    occ = (rc[i] - m_cnt[i]) & mask;
                    if (occ < depth && $urandom_range(0, 99) < pr) rc[i] = (rc[i] + 1) & mask;
                end
                set_rem(i, gray_of(rc[i]));
                inc[i] = ($urandom_range(0, 99) < pin);
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
